// File: rtl/bridge_drv.sv
// bridge_drv -- full-bridge gate driver sequencer for a resonant converter.
// Follows the resonant current phase (fb) once it is seen toggling, and falls
// back to an internal start oscillator when feedback is absent or lost.
// Every leg change passes through a dead band of DEAD_CNT cycles with both
// gate commands low.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   en       bridge enable (interrupter), synchronous to clk
//   fb       raw current-phase feedback, asynchronous to clk
//   out_a    high-side gate command, leg A
//   out_b    high-side gate command, leg B
//   fb_lost  high while the internal start oscillator is the phase source
module bridge_drv #(
  parameter int DEAD_CNT   = 4,
  parameter int START_HALF = 50,
  parameter int FB_TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic fb,
  output logic out_a,
  output logic out_b,
  output logic fb_lost
);

  localparam int DW = $clog2(DEAD_CNT + 1);
  localparam int OW = $clog2(START_HALF + 1);
  localparam int TW = $clog2(FB_TIMEOUT + 1);

  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CNT - 1);
  localparam logic [OW-1:0] OSC_LAST  = OW'(START_HALF - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(FB_TIMEOUT);

  typedef enum logic [1:0] {IDLE, DEAD, A_ON, B_ON} state_t;

  // feedback synchronizer and edge detect
  logic fb_m, fb_s, fb_s_d;
  logic fb_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_m   <= 1'b0;
      fb_s   <= 1'b0;
      fb_s_d <= 1'b0;
    end else begin
      fb_m   <= fb;
      fb_s   <= fb_m;
      fb_s_d <= fb_s;
    end
  end

  assign fb_edge = fb_s ^ fb_s_d;

  // feedback timeout: counts quiet enabled cycles, saturating at FB_TIMEOUT
  logic [TW-1:0] tcnt, tcnt_n;
  logic          fb_valid, fb_valid_n;

  always_comb begin
    tcnt_n = tcnt;
    if (!en || fb_edge)   tcnt_n = '0;
    else if (tcnt != TO_MAX) tcnt_n = tcnt + 1'b1;
  end

  // an edge always wins over the timeout
  always_comb begin
    fb_valid_n = fb_valid;
    if (fb_edge)               fb_valid_n = 1'b1;
    else if (tcnt_n == TO_MAX) fb_valid_n = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt     <= '0;
      fb_valid <= 1'b0;
      fb_lost  <= 1'b1;
    end else begin
      tcnt     <= tcnt_n;
      fb_valid <= fb_valid_n;
      fb_lost  <= ~fb_valid_n;
    end
  end

  // start oscillator: held high while disabled so the first leg is always A
  logic [OW-1:0] ocnt;
  logic          osc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocnt <= '0;
      osc  <= 1'b1;
    end else if (!en) begin
      ocnt <= '0;
      osc  <= 1'b1;
    end else if (ocnt == OSC_LAST) begin
      ocnt <= '0;
      osc  <= ~osc;
    end else begin
      ocnt <= ocnt + 1'b1;
    end
  end

  logic phase;
  assign phase = fb_valid ? fb_s : osc;

  // leg sequencer
  state_t        state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    case (state)
      IDLE: begin
        state_n = DEAD;
        dcnt_n  = '0;
      end
      DEAD: begin
        // phase is only looked at on the last dead cycle; earlier wiggles
        // neither restart nor shorten the band
        if (dcnt == DEAD_LAST) state_n = phase ? A_ON : B_ON;
        else                   dcnt_n  = dcnt + 1'b1;
      end
      A_ON: begin
        if (!phase) begin
          state_n = DEAD;
          dcnt_n  = '0;
        end
      end
      B_ON: begin
        if (phase) begin
          state_n = DEAD;
          dcnt_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        dcnt_n  = '0;
      end
    endcase
    if (!en) begin
      state_n = IDLE;
      dcnt_n  = '0;
    end
  end

  // outputs registered from the next state so they line up with the state
  // register and can never both be high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a <= 1'b0;
      out_b <= 1'b0;
    end else begin
      out_a <= (state_n == A_ON);
      out_b <= (state_n == B_ON);
    end
  end

endmodule

// File: tb/tb_bridge_drv.sv
// tb_bridge_drv -- directed + randomized bench for bridge_drv with a
// cycle-level behavioural reference model and per-cycle output checks.
module tb_bridge_drv;

  localparam int DEAD_CNT   = 4;
  localparam int START_HALF = 50;
  localparam int FB_TIMEOUT = 200;
  localparam int WAIT_MAX   = 600;

  logic clk = 1'b0;
  logic rst, en, fb;
  logic out_a, out_b, fb_lost;

  int n_assert = 0;
  int n_fail   = 0;

  bridge_drv #(
    .DEAD_CNT  (DEAD_CNT),
    .START_HALF(START_HALF),
    .FB_TIMEOUT(FB_TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .fb     (fb),
    .out_a  (out_a),
    .out_b  (out_b),
    .fb_lost(fb_lost)
  );

  always #5 clk = ~clk;

  // reference model state
  bit m_s1, m_fbs, m_fbs_last; // two-stage sync and previous fb_s
  bit m_valid;                 // feedback currently trusted
  int m_quiet;                 // enabled cycles since last fb_s change
  int m_ocyc;                  // enabled cycles since en rose
  int m_leg;                   // 0 idle, 1 dead band, 2 leg A, 3 leg B
  int m_dead;                  // dead cycles already served
  // independent dead-band observer on the DUT outputs
  int last_leg;
  int lows;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_fbs = 0; m_fbs_last = 0;
    m_valid = 0; m_quiet = 0; m_ocyc = 0;
    m_leg = 0; m_dead = 0;
    last_leg = 0; lows = DEAD_CNT;
  endtask

  // one clock: advance the model on the rising edge, check on the falling edge
  task automatic tick();
    bit edge_, osc_, phase_, v_n;
    int q_n;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      edge_  = (m_fbs != m_fbs_last);
      osc_   = ((m_ocyc / START_HALF) % 2) == 0;
      phase_ = m_valid ? m_fbs : osc_;
      if (!en || edge_) q_n = 0;
      else              q_n = (m_quiet < FB_TIMEOUT) ? m_quiet + 1 : FB_TIMEOUT;
      v_n = edge_ ? 1'b1 : ((q_n == FB_TIMEOUT) ? 1'b0 : m_valid);
      if (!en) begin
        m_leg = 0;
      end else begin
        case (m_leg)
          0: begin m_leg = 1; m_dead = 0; end
          1: begin
            m_dead++;
            if (m_dead == DEAD_CNT) m_leg = phase_ ? 2 : 3;
          end
          2: if (!phase_) begin m_leg = 1; m_dead = 0; end
          default: if (phase_) begin m_leg = 1; m_dead = 0; end
        endcase
      end
      m_ocyc     = en ? m_ocyc + 1 : 0;
      m_fbs_last = m_fbs;
      m_fbs      = m_s1;
      m_s1       = fb;
      m_quiet    = q_n;
      m_valid    = v_n;
    end
    @(negedge clk);
    chk("out_a", out_a, m_leg == 2);
    chk("out_b", out_b, m_leg == 3);
    chk("fb_lost", fb_lost, !m_valid);
    chk("no_overlap", out_a & out_b, 1'b0);
    if (out_a | out_b) begin
      if (last_leg != 0 && last_leg != (out_a ? 1 : 2))
        chk("dead_band_len", lows >= DEAD_CNT, 1'b1);
      last_leg = out_a ? 1 : 2;
      lows = 0;
    end else lows++;
  endtask

  initial begin
    int i;
    rst = 1'b1; en = 1'b0; fb = 1'b0;
    model_reset();
    tick(); tick();
    chk("rst_out_a", out_a, 1'b0);
    chk("rst_out_b", out_b, 1'b0);
    chk("rst_fb_lost", fb_lost, 1'b1);

    // start-up on the oscillator
    rst = 1'b0; en = 1'b1;
    repeat (260) tick();

    // feedback lock at period 37
    for (i = 0; i < 400; i++) begin
      if (i % 37 == 36) fb = ~fb;
      tick();
    end

    // feedback loss, oscillator takes over
    repeat (300) tick();
    chk("loss_fb_lost", fb_lost, 1'b1);

    // random-period feedback
    for (i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) fb = ~fb;
      tick();
    end

    // interrupter cut while leg B is driven
    for (i = 0; i < WAIT_MAX && !out_b; i++) tick();
    chk("wait_out_b", out_b, 1'b1);
    en = 1'b0;
    tick();
    chk("cut_out_b", out_b, 1'b0);
    repeat (5) tick();
    en = 1'b1;

    // feedback at 37 again, then 2-cycle pulses inside dead bands
    for (i = 0; i < 200; i++) begin
      if (i % 37 == 36) fb = ~fb;
      tick();
    end
    repeat (3) begin
      for (i = 0; i < WAIT_MAX && !(out_a | out_b); i++) tick();
      for (i = 0; i < WAIT_MAX && (out_a | out_b); i++) begin
        if (i % 37 == 36) fb = ~fb;
        tick();
      end
      chk("wait_dead", out_a | out_b, 1'b0);
      fb = ~fb; tick(); tick();
      fb = ~fb;
      repeat (20) tick();
    end

    // random en and fb activity
    for (i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)  fb = ~fb;
      if ($urandom_range(0, 149) == 0) en = ~en;
      tick();
    end
    en = 1'b1;
    repeat (250) tick();

    // async reset between edges while leg A is on
    for (i = 0; i < WAIT_MAX && !out_a; i++) tick();
    chk("wait_out_a", out_a, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_out_a", out_a, 1'b0);
    chk("async_out_b", out_b, 1'b0);
    chk("async_fb_lost", fb_lost, 1'b1);
    tick();
    rst = 1'b0;
    repeat (120) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
